// File: rtl/mc_defs.sv
// rtl/mc_defs.sv - shared encodings for the multi-cycle MIPS control unit
// Purpose: state encodings, opcode/funct constants, datapath select codes and
//          the instruction-class one-hot shared by mc_decode and mc_ctrl.
// Ports:   none (package).
package mc_defs;

  localparam int RA_REG = 31;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXE    = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] ALU_ADDU  = 3'd0;
  localparam logic [2:0] ALU_SUBU  = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] RDST_RT = 2'd0;
  localparam logic [1:0] RDST_RD = 2'd1;
  localparam logic [1:0] RDST_RA = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;

  // At most one bit set; all-zero means the encoding is unsupported.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } icls_t;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - opcode/funct to instruction-class one-hot
// Purpose: combinational classification of the instruction held in IR.
// Ports:   op_i [5:0], funct_i [5:0] in; cls_o (icls_t one-hot), illegal_o out.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  output icls_t      cls_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o = '0;
    unique case (op_i)
      OP_RTYPE: begin
        cls_o.addu = (funct_i == FN_ADDU);
        cls_o.subu = (funct_i == FN_SUBU);
        cls_o.jr   = (funct_i == FN_JR);
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: cls_o = '0;
    endcase
  end

  assign illegal_o = ~|cls_o;

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control unit FSM
// Purpose: sequences FETCH/DECODE/EXE/MEM/WB over a shared datapath and a
//          unified single-port memory with a req/ready handshake.
// Ports:   clk, reset (async active-low), op/funct (from IR), zero, mem_ready in;
//          mem_req, pc_wr, ir_wr, reg_wr, mem_wr, sign_ext, lui_ext, alu_ctr,
//          alu_src, reg_dst, mem_to_reg, npc_op, state, instr_done, illegal out.
module mc_ctrl
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       mem_wr,
  output logic       sign_ext,
  output logic       lui_ext,
  output logic [2:0] alu_ctr,
  output logic       alu_src,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic [1:0] npc_op,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       illegal
);

  logic [2:0] state_q, state_d;
  icls_t      cls;
  logic       unsupported;

  mc_decode u_decode (
    .op_i      (op),
    .funct_i   (funct),
    .cls_o     (cls),
    .illegal_o (unsupported)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = (cls.j || cls.jal || cls.jr || unsupported) ? S_FETCH : S_EXE;
      S_EXE: begin
        if (cls.lw || cls.sw) state_d = S_MEM;
        else if (cls.beq)     state_d = S_FETCH;
        else                  state_d = S_WB;
      end
      S_MEM: begin
        if (!mem_ready)   state_d = S_MEM;
        else if (cls.lw)  state_d = S_WB;
        else              state_d = S_FETCH;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    sign_ext   = 1'b0;
    lui_ext    = 1'b0;
    alu_ctr    = ALU_ADDU;
    alu_src    = 1'b0;
    reg_dst    = RDST_RT;
    mem_to_reg = WD_ALU;
    npc_op     = NPC_PC4;
    instr_done = 1'b0;
    illegal    = 1'b0;

    // Outputs are gated by reset so enables drop the instant reset asserts,
    // not at the next edge.
    if (reset) begin
      // ALU/extender setup is held from EXE through MEM and WB so the
      // address or result feeding memory/GRF stays stable.
      if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
        if (cls.subu || cls.beq) alu_ctr = ALU_SUBU;
        if (cls.ori)             alu_ctr = ALU_OR;
        if (cls.lui)             alu_ctr = ALU_PASSB;
        alu_src  = cls.ori || cls.lui || cls.lw || cls.sw;
        sign_ext = cls.lw || cls.sw || cls.beq;
        lui_ext  = cls.lui;
      end

      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_wr   = mem_ready;
          pc_wr   = mem_ready;
        end
        S_DECODE: begin
          if (cls.j || cls.jal) begin
            pc_wr      = 1'b1;
            npc_op     = NPC_JMP;
            instr_done = 1'b1;
          end
          // jal writes PC+4 of the jal itself; the PC only updates at this edge.
          if (cls.jal) begin
            reg_wr     = 1'b1;
            reg_dst    = RDST_RA;
            mem_to_reg = WD_PC4;
          end
          if (cls.jr) begin
            pc_wr      = 1'b1;
            npc_op     = NPC_JR;
            instr_done = 1'b1;
          end
          if (unsupported) begin
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_EXE: begin
          if (cls.beq) begin
            pc_wr      = zero;
            npc_op     = NPC_BR;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          if (cls.sw) begin
            mem_wr     = mem_ready;
            instr_done = mem_ready;
          end
        end
        S_WB: begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
          if (cls.addu || cls.subu) reg_dst = RDST_RD;
          if (cls.lw)               mem_to_reg = WD_DM;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle MIPS control unit for the P5 datapath.
- Sequences one shared datapath through FETCH/DECODE/EXE/MEM/WB. Drives PC/IR/GRF/DM write enables, ALU control, next-PC select and extender mode (sign_ext, lui_ext) per instruction and per cycle.
- Waits on a single-port unified memory through a req/ready handshake.
- Sits between the IR (opcode/funct source) and all datapath muxes and enables.

Parameters:
- RA_REG, 31, register index written by jal (used by the datapath via reg_dst=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces state FETCH.
- op  in  6  IR[31:26], stable from DECODE until the next FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU equality flag, valid in EXE.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- pc_wr  out  1  PC load enable.
- ir_wr  out  1  IR load enable.
- reg_wr  out  1  GRF write enable.
- mem_wr  out  1  DM write (qualified by mem_ready).
- sign_ext  out  1  extender signed mode.
- lui_ext  out  1  extender lui mode.
- alu_ctr  out  3  0 addu, 1 subu, 2 or, 3 pass-B.
- alu_src  out  1  0 = rt data, 1 = extended immediate.
- reg_dst  out  2  0 rt, 1 rd, 2 RA_REG.
- mem_to_reg  out  2  0 ALU, 1 DM data, 2 PC+4.
- npc_op  out  2  0 PC+4, 1 branch, 2 j/jal target, 3 rs (jr).
- state  out  3  current state, for debug.
- instr_done  out  1  1-cycle pulse in an instruction's final cycle.
- illegal  out  1  1-cycle pulse in DECODE for an unsupported encoding.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4. Registered. Outputs are combinational from state, op, funct, zero and mem_ready.
- Reset (reset=0, asynchronous): state=FETCH. While reset is held, every output is 0 except mem_req, which is 0 during reset and becomes 1 in the first FETCH cycle after release.
- FETCH:
  - mem_req=1.
  - If mem_ready=1: ir_wr=1, pc_wr=1 with npc_op=0, go to DECODE.
  - Otherwise hold FETCH with all enables 0 (unbounded wait).
- DECODE:
  - Supported: addu/subu (op 0, funct 0x21/0x23), jr (op 0, funct 0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
  - j: pc_wr=1, npc_op=2, instr_done=1, go to FETCH.
  - jal: pc_wr=1, npc_op=2, reg_wr=1, reg_dst=2, mem_to_reg=2, instr_done=1, go to FETCH. The GRF write uses the old PC+4, captured before the PC updates.
  - jr: pc_wr=1, npc_op=3, instr_done=1, go to FETCH.
  - Unsupported encoding: illegal=1, instr_done=1, go to FETCH with no write. It behaves as a nop.
  - All other supported instructions go to EXE.
- EXE:
  - addu/subu: alu_ctr 0/1, alu_src=0, go to WB.
  - ori: alu_ctr=2, alu_src=1, sign_ext=0, go to WB.
  - lui: lui_ext=1, alu_ctr=3, alu_src=1, go to WB.
  - lw/sw: sign_ext=1, alu_src=1, alu_ctr=0, go to MEM.
  - beq: alu_ctr=1, sign_ext=1. pc_wr=zero, npc_op=1, instr_done=1, go to FETCH.
- MEM:
  - mem_req=1, and the ALU/extender controls from EXE are held.
  - sw: mem_wr=mem_ready. When mem_ready=1, instr_done=1 and go to FETCH.
  - lw: when mem_ready=1, go to WB.
  - Without mem_ready, hold MEM.
- WB:
  - reg_wr=1, instr_done=1, go to FETCH.
  - R-type: reg_dst=1, mem_to_reg=0.
  - ori/lui: reg_dst=0, mem_to_reg=0.
  - lw: reg_dst=0, mem_to_reg=1.
  - EXE controls are held in WB so the ALU result stays stable.
- Cycle counts with zero-wait memory: j/jal/jr 2; beq 3; addu/subu/ori/lui/sw 4; lw 5. Each memory wait cycle adds 1.
- Write exclusivity: pc_wr, reg_wr and mem_wr never assert outside the cases above. Exactly one instr_done pulse per instruction.
- Reset mid-instruction (including during a MEM wait): immediate return to FETCH. Any enable that was high drops asynchronously.
- Any unreachable state encoding (5-7): treated as FETCH on the next edge, with all outputs 0.

Decomposition:
- Shared package mc_defs: state encodings, opcode/funct constants, ALU_ADDU..ALU_PASSB, NPC_*, RDST_*, WD_*.
- Sub-module mc_decode (combinational op/funct to instruction-class one-hot); the FSM core remains in mc_ctrl.

Test Plan:
- reset=0 mid-MEM of sw, then release -> state=0, mem_wr=0 immediately. mem_req=1 on the next cycle. No instr_done for the aborted sw.
- ori (op 0x0D), mem_ready always 1 -> states 0,1,2,4 in that order. EXE: alu_ctr=2, alu_src=1, sign_ext=0. WB: reg_wr=1, reg_dst=0, instr_done=1.
- lw with mem_ready low for 2 cycles in MEM -> MEM held 3 cycles, then WB with mem_to_reg=1, reg_wr=1. Total 7 cycles.
- beq, zero=1 then zero=0 -> pc_wr=1 with npc_op=1 in EXE for the first; pc_wr=0 for the second. Both take 3 cycles.
- jal -> DECODE: pc_wr=1, reg_wr=1, reg_dst=2, mem_to_reg=2, npc_op=2. Back in FETCH the next cycle.
- op=0x3F, then op=0 with funct=0x2A -> illegal pulses in DECODE, with no pc_wr/reg_wr/mem_wr. FETCH follows.
